// File: rtl/tama_sched_pkg.sv
// Shared action ids, FSM state type and the rotating-priority pick used by action_scheduler.
package tama_sched_pkg;

  localparam int NUM_ACT = 6;
  localparam int NUM_REQ = 5;

  localparam logic [2:0] ACT_COMER  = 3'd0;
  localparam logic [2:0] ACT_CURAR  = 3'd1;
  localparam logic [2:0] ACT_JUGAR  = 3'd2;
  localparam logic [2:0] ACT_DORMIR = 3'd3;
  localparam logic [2:0] ACT_TEMP   = 3'd4;
  localparam logic [2:0] ACT_DECAY  = 3'd5;

  typedef enum logic {ST_IDLE, ST_ISSUE} sched_state_t;

  // First set bit of pend found by scanning upward from start, wrapping 5->0.
  function automatic logic [2:0] prio_pick(input logic [NUM_ACT-1:0] pend, input logic [2:0] start);
    logic [2:0] pick;
    int idx;
    pick = start;
    for (int k = NUM_ACT - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_ACT) idx -= NUM_ACT;
      if (pend[3'(idx)]) pick = 3'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second time base; test_en shortens the second by TEST_SPEEDUP and any test_en change restarts it.
module sec_prescaler #(
  parameter int CLK_FREQ     = 50000000,
  parameter int TEST_SPEEDUP = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic test_en,
  output logic sec_tick
);

  localparam int CW = $clog2(CLK_FREQ);
  localparam logic [CW-1:0] TERM_NORM = CW'(CLK_FREQ - 1);
  localparam logic [CW-1:0] TERM_TEST = CW'(CLK_FREQ / TEST_SPEEDUP - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          test_en_q;

  assign term = test_en ? TERM_TEST : TERM_NORM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      test_en_q <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      test_en_q <= test_en;
      sec_tick  <= 1'b0;
      if (test_en != test_en_q) begin
        cnt <= '0;
      end else if (cnt == term) begin
        cnt      <= '0;
        sec_tick <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/action_scheduler.sv
// Action request scheduler: sync + edge detect, cooldowns, decay timer, one-at-a-time command issue.
// Define SCHED_RR_EN for round-robin arbitration (default: fixed priority, lowest id wins).
module action_scheduler
  import tama_sched_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int TEST_SPEEDUP  = 10,
  parameter int COOLDOWN_SECS = 3,
  parameter int DECAY_SECS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       test_en,
  input  logic [4:0] req,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_id,
  output logic [5:0] pending,
  output logic       sec_tick
);

  localparam int CDW = $clog2(COOLDOWN_SECS + 1);
  localparam int DW  = $clog2(DECAY_SECS + 1);
  localparam logic [CDW-1:0] CD_LOAD    = CDW'(COOLDOWN_SECS);
  localparam logic [DW-1:0]  DECAY_LAST = DW'(DECAY_SECS - 1);

  logic [NUM_REQ-1:0] req_p0, req_p1, req_p2, req_rise;
  logic [CDW-1:0]     cooldown [NUM_REQ];
  logic [DW-1:0]      decay_cnt;
  logic               decay_set;
  logic               hs;
  logic [2:0]         start_id, winner;
  sched_state_t       state, state_nxt;

  sec_prescaler #(
    .CLK_FREQ    (CLK_FREQ),
    .TEST_SPEEDUP(TEST_SPEEDUP)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .test_en (test_en),
    .sec_tick(sec_tick)
  );

  assign hs        = cmd_valid & cmd_ready;
  assign decay_set = sec_tick && (decay_cnt == DECAY_LAST);

  // p0/p1: synchronizer, p2: previous synchronized level for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_p0 <= '0;
      req_p1 <= '0;
      req_p2 <= '0;
    end else begin
      req_p0 <= req;
      req_p1 <= req_p0;
      req_p2 <= req_p1;
    end
  end

  assign req_rise = req_p1 & ~req_p2;

  // Handshake clear beats a same-cycle edge; decay set beats a same-cycle DECAY clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs && cmd_id == 3'(i))
          pending[i] <= 1'b0;
        else if (req_rise[i] && cooldown[i] == '0)
          pending[i] <= 1'b1;
      end
      if (decay_set)
        pending[ACT_DECAY] <= 1'b1;
      else if (hs && cmd_id == ACT_DECAY)
        pending[ACT_DECAY] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) cooldown[i] <= '0;
      decay_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs && cmd_id == 3'(i))
          cooldown[i] <= CD_LOAD;
        else if (sec_tick && cooldown[i] != '0)
          cooldown[i] <= cooldown[i] - 1'b1;
      end
      if (sec_tick)
        decay_cnt <= decay_set ? '0 : decay_cnt + 1'b1;
    end
  end

`ifdef SCHED_RR_EN
  logic [2:0] rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= ACT_DECAY;
    else if (hs)
      rr_ptr <= cmd_id;
  end

  assign start_id = (rr_ptr == ACT_DECAY) ? ACT_COMER : rr_ptr + 3'd1;
`else
  assign start_id = ACT_COMER;
`endif

  assign winner = prio_pick(pending, start_id);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cmd_id <= ACT_COMER;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pending != '0)
        cmd_id <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pending != '0) state_nxt = ST_ISSUE;
      ST_ISSUE: if (cmd_ready)     state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ST_ISSUE);
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Directed self-checking bench for action_scheduler with the small simulation parameter set.
module tb_action_scheduler;

  localparam int CLK_FREQ      = 100;
  localparam int TEST_SPEEDUP  = 10;
  localparam int COOLDOWN_SECS = 2;
  localparam int DECAY_SECS    = 5;

`ifdef SCHED_RR_EN
  localparam logic [2:0] EXP_FIRST  = 3'd2;
  localparam logic [2:0] EXP_SECOND = 3'd0;
`else
  localparam logic [2:0] EXP_FIRST  = 3'd0;
  localparam logic [2:0] EXP_SECOND = 3'd2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       test_en;
  logic [4:0] req;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic [5:0] pending;
  logic       sec_tick;

  int errors = 0;
  int checks = 0;

  action_scheduler #(
    .CLK_FREQ     (CLK_FREQ),
    .TEST_SPEEDUP (TEST_SPEEDUP),
    .COOLDOWN_SECS(COOLDOWN_SECS),
    .DECAY_SECS   (DECAY_SECS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .test_en  (test_en),
    .req      (req),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_id   (cmd_id),
    .pending  (pending),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; cmd_ready = 1'b0; test_en = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // Returns the number of cycles until sec_tick is seen, or -1 after limit cycles.
  task automatic wait_tick(input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (sec_tick === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; cmd_ready = 1'b0; test_en = 1'b0;
    #3;
    step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (cmd_id !== 3'd0) begin errors++; $display("FAIL reset_cmd_id: got %0d want 0", cmd_id); end
    checks++; if (pending !== 6'h00) begin errors++; $display("FAIL reset_pending: got %b want 000000", pending); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick: got %b want 0", sec_tick); end
  endtask

  task automatic test_latency();
    do_reset();
    cmd_ready = 1'b1;
    req = 5'b00001;
    step();
    req = '0;
    step();
    step();
    checks++; if (pending !== 6'h01 || cmd_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2: pending=%b valid=%b want 000001/0", pending, cmd_valid); end
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd0) begin errors++; $display("FAIL lat_edge3: valid=%b id=%0d want 1/0", cmd_valid, cmd_id); end
    step();
    checks++; if (cmd_valid !== 1'b0 || pending !== 6'h00) begin errors++; $display("FAIL lat_after_hs: valid=%b pending=%b want 0/000000", cmd_valid, pending); end
  endtask

  task automatic test_backpressure();
    bit held_ok;
    do_reset();
    cmd_ready = 1'b0;
    req = 5'b01010;
    step(); step(); step(); step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd1) begin errors++; $display("FAIL bp_first: valid=%b id=%0d want 1/1", cmd_valid, cmd_id); end
    held_ok = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (cmd_valid !== 1'b1 || cmd_id !== 3'd1) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL bp_hold: held=%b want 1 (last valid=%b id=%0d)", held_ok, cmd_valid, cmd_id); end
    cmd_ready = 1'b1;
    step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_gap: valid=%b want 0", cmd_valid); end
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd3) begin errors++; $display("FAIL bp_second: valid=%b id=%0d want 1/3", cmd_valid, cmd_id); end
    step();
    checks++; if (cmd_valid !== 1'b0 || pending !== 6'h00) begin errors++; $display("FAIL bp_drain: valid=%b pending=%b want 0/000000", cmd_valid, pending); end
    req = '0;
  endtask

  task automatic test_cooldown();
    bit quiet;
    int cyc;
    do_reset();
    cmd_ready = 1'b1;
    req = 5'b00001;
    step();
    req = '0;
    step(); step(); step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd0) begin errors++; $display("FAIL cd_grant: valid=%b id=%0d want 1/0", cmd_valid, cmd_id); end
    step();
    for (int n = 0; n < 50; n++) step();
    req = 5'b00001;
    step();
    req = '0;
    quiet = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      if (cmd_valid !== 1'b0 || pending !== 6'h00) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL cd_discard: quiet=%b want 1 (pending=%b)", quiet, pending); end
    wait_tick(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL cd_tick1: cycles=%0d want >0", cyc); end
    wait_tick(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL cd_tick2: cycles=%0d want >0", cyc); end
    req = 5'b00001;
    step();
    req = '0;
    step(); step();
    checks++; if (pending !== 6'h01) begin errors++; $display("FAIL cd_reaccept: pending=%b want 000001", pending); end
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd0) begin errors++; $display("FAIL cd_regrant: valid=%b id=%0d want 1/0", cmd_valid, cmd_id); end
    step();
  endtask

  task automatic test_timebase();
    int cyc;
    do_reset();
    cmd_ready = 1'b0;
    wait_tick(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL tb_tick1: cycles=%0d want >0", cyc); end
    wait_tick(200, cyc);
    checks++; if (cyc !== 100) begin errors++; $display("FAIL tb_period_norm: cycles=%0d want 100", cyc); end
    wait_tick(200, cyc);
    wait_tick(200, cyc);
    checks++; if (pending !== 6'h00) begin errors++; $display("FAIL decay_early: pending=%b want 000000 after 4 ticks", pending); end
    wait_tick(200, cyc);
    checks++; if (cyc !== 100) begin errors++; $display("FAIL tb_tick5: cycles=%0d want 100", cyc); end
    step();
    checks++; if (pending !== 6'h20) begin errors++; $display("FAIL decay_set: pending=%b want 100000", pending); end
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd5) begin errors++; $display("FAIL decay_issue: valid=%b id=%0d want 1/5", cmd_valid, cmd_id); end
    test_en = 1'b1;
    wait_tick(50, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL tb_test_first: cycles=%0d want >0", cyc); end
    wait_tick(50, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL tb_period_test: cycles=%0d want 10", cyc); end
    test_en = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    bit quiet;
    do_reset();
    cmd_ready = 1'b0;
    req = 5'b00001;
    step();
    req = '0;
    step(); step(); step();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rmi_setup: valid=%b want 1", cmd_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0 || pending !== 6'h00) begin errors++; $display("FAIL rmi_async: valid=%b pending=%b want 0/000000", cmd_valid, pending); end
    step(); step();
    rst = 1'b1;
    quiet = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      if (cmd_valid !== 1'b0 || pending !== 6'h00) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rmi_no_replay: quiet=%b want 1 (valid=%b pending=%b)", quiet, cmd_valid, pending); end
  endtask

  task automatic test_arbitration();
    int cyc;
    do_reset();
    cmd_ready = 1'b1;
    req = 5'b00001;
    step();
    req = '0;
    step(); step(); step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 3'd0) begin errors++; $display("FAIL arb_grant0: valid=%b id=%0d want 1/0", cmd_valid, cmd_id); end
    step();
    wait_tick(200, cyc);
    wait_tick(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL arb_ticks: cycles=%0d want >0", cyc); end
    cmd_ready = 1'b0;
    req = 5'b00101;
    step();
    req = '0;
    step(); step(); step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== EXP_FIRST) begin errors++; $display("FAIL arb_first: valid=%b id=%0d want 1/%0d", cmd_valid, cmd_id, EXP_FIRST); end
    cmd_ready = 1'b1;
    step();
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== EXP_SECOND) begin errors++; $display("FAIL arb_second: valid=%b id=%0d want 1/%0d", cmd_valid, cmd_id, EXP_SECOND); end
    step();
    checks++; if (pending !== 6'h00) begin errors++; $display("FAIL arb_drain: pending=%b want 000000", pending); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_cooldown();
    test_timebase();
    test_reset_mid_issue();
    test_arbitration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
